// File: rtl/defines_pkg.sv
`default_nettype none
// =============================================================================
// defines_pkg : shared types for the dataflow fabric processing elements
// Rev 1.0 - initial release
// =============================================================================
package defines_pkg;

    typedef enum logic [1:0] {
        PE_OR  = 2'd0,
        PE_AND = 2'd1,
        PE_XOR = 2'd2,
        PE_ADD = 2'd3
    } pe_op_e;

endpackage
`default_nettype wire

// File: rtl/pe_delay_line.sv
`default_nettype none
// =============================================================================
// pe_delay_line : enable-gated valid/data shift register, head is stage DEPTH-1
// Rev 1.0 - initial release
// =============================================================================
module pe_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_v,
    output logic [WIDTH-1:0] out_d,
    output logic [DEPTH-1:0] v
);

    logic [DEPTH-1:0][WIDTH-1:0] d;

    // Data of a bubble entering s0 is not loaded, so idle stages keep old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            d <= '0;
        end else if (en) begin
            v[0] <= in_v;
            if (in_v) begin
                d[0] <= in_d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign out_v = v[DEPTH-1];
    assign out_d = d[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pe_join_fork.sv
`default_nettype none
// =============================================================================
// pe_join_fork : NUM_IN-way join, runtime reduction, elastic delay, NUM_OUT fork
// Rev 1.0 - initial release
// =============================================================================
module pe_join_fork
    import defines_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 15,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  pe_op_e                         op,
    input  logic [NUM_IN-1:0][WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]              in_valid,
    output logic [NUM_IN-1:0]              in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [NUM_OUT-1:0]             out_valid,
    input  logic [NUM_OUT-1:0]             out_ready,
    output logic [31:0]                    fire_count,
    output logic                           busy
);

    logic               v_head;
    logic               retire;
    logic               stall;
    logic               fire;
    logic               enter_v;
    logic [WIDTH-1:0]   result;
    logic [NUM_OUT-1:0] pending;
    logic [LATENCY-1:0] stage_v;

    assign retire = v_head & ((pending & ~out_ready) == '0);
    assign stall  = v_head & ~retire;
    // Reset gating keeps in_ready low while rst is held with valid inputs.
    assign fire     = (&in_valid) & ~stall & ~rst;
    assign in_ready = {NUM_IN{fire}};

    always_comb begin
        result = in_data[0];
        for (int i = 1; i < NUM_IN; i++) begin
            case (op)
                PE_OR:   result = result | in_data[i];
                PE_AND:  result = result & in_data[i];
                PE_XOR:  result = result ^ in_data[i];
                PE_ADD:  result = result + in_data[i];
                default: result = result | in_data[i];
            endcase
        end
    end

    pe_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .en    (~stall),
        .in_v  (fire),
        .in_d  (result),
        .out_v (v_head),
        .out_d (out_data),
        .v     (stage_v)
    );

    // Valid bit of whichever token moves into the head on an unstalled edge.
    generate
        if (LATENCY == 1) begin : g_enter_fire
            assign enter_v = fire;
        end else begin : g_enter_stage
            assign enter_v = stage_v[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (!stall) begin
            pending <= {NUM_OUT{enter_v}};
        end else begin
            pending <= pending & ~out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_count <= '0;
        end else if (fire) begin
            fire_count <= fire_count + 32'd1;
        end
    end

    assign out_valid = {NUM_OUT{v_head}} & pending;
    assign busy      = |stage_v;

endmodule
`default_nettype wire

// File: tb/tb_pe_join_fork.sv
`default_nettype none
// =============================================================================
// tb_pe_join_fork : scoreboard bench for two configurations of pe_join_fork
// Rev 1.0 - initial release
// =============================================================================
module tb_pe_join_fork;
    import defines_pkg::*;

    localparam int LAT_A = 15;
    localparam int LAT_B = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    // DUT A: default parameters
    pe_op_e           op_a;
    logic [1:0][15:0] in_data_a;
    logic [1:0]       in_valid_a;
    logic [1:0]       in_ready_a;
    logic [15:0]      out_data_a;
    logic [0:0]       out_valid_a;
    logic [0:0]       out_ready_a;
    logic [31:0]      fire_count_a;
    logic             busy_a;

    // DUT B: 3-in, 2-out, 8-bit
    pe_op_e           op_b;
    logic [2:0][7:0]  in_data_b;
    logic [2:0]       in_valid_b;
    logic [2:0]       in_ready_b;
    logic [7:0]       out_data_b;
    logic [1:0]       out_valid_b;
    logic [1:0]       out_ready_b;
    logic [31:0]      fire_count_b;
    logic             busy_b;

    pe_join_fork dut_a (
        .clk        (clk),
        .rst        (rst),
        .op         (op_a),
        .in_data    (in_data_a),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .out_data   (out_data_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .fire_count (fire_count_a),
        .busy       (busy_a)
    );

    pe_join_fork #(
        .WIDTH   (8),
        .LATENCY (LAT_B),
        .NUM_IN  (3),
        .NUM_OUT (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .op         (op_b),
        .in_data    (in_data_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .out_data   (out_data_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .fire_count (fire_count_b),
        .busy       (busy_b)
    );

    typedef struct {
        logic [15:0] d;
        int          stamp;   // expected handshake cycle, -1 when not timed
    } exp_t;

    exp_t qa[$];
    exp_t qb0[$];
    exp_t qb1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_tok(input string nm, input logic [15:0] act, input exp_t e);
        chk(nm, {48'd0, act}, {48'd0, e.d});
        if (e.stamp >= 0) chk({nm, "_cycle"}, 64'(cyc), 64'(e.stamp));
    endtask

    // Monitor: every consumer handshake pops that consumer's queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid_a[0] && out_ready_a[0]) begin
                if (qa.size() == 0) chk("a_out_unexpected", 64'd1, 64'd0);
                else begin e = qa.pop_front(); chk_tok("a_out", out_data_a, e); end
            end
            if (out_valid_b[0] && out_ready_b[0]) begin
                if (qb0.size() == 0) chk("b0_out_unexpected", 64'd1, 64'd0);
                else begin e = qb0.pop_front(); chk_tok("b0_out", {8'd0, out_data_b}, e); end
            end
            if (out_valid_b[1] && out_ready_b[1]) begin
                if (qb1.size() == 0) chk("b1_out_unexpected", 64'd1, 64'd0);
                else begin e = qb1.pop_front(); chk_tok("b1_out", {8'd0, out_data_b}, e); end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the token is accepted.
    task automatic send_a(input logic [15:0] x0, input logic [15:0] x1, input pe_op_e o,
                          input logic [15:0] exp, input bit timed);
        int k;
        in_data_a[0] = x0;
        in_data_a[1] = x1;
        op_a         = o;
        in_valid_a   = 2'b11;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready_a === 2'b11) break;
        end
        if (k == 100) chk("a_accept_timeout", 64'd1, 64'd0);
        else qa.push_back('{exp, timed ? cyc + LAT_A : -1});
        @(posedge clk); #1;
        in_valid_a = 2'b00;
    endtask

    task automatic send_b(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                          input pe_op_e o, input logic [7:0] exp, input bit timed);
        int k;
        in_data_b[0] = x0;
        in_data_b[1] = x1;
        in_data_b[2] = x2;
        op_b         = o;
        in_valid_b   = 3'b111;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready_b === 3'b111) break;
        end
        if (k == 100) chk("b_accept_timeout", 64'd1, 64'd0);
        else begin
            qb0.push_back('{{8'd0, exp}, timed ? cyc + LAT_B : -1});
            qb1.push_back('{{8'd0, exp}, timed ? cyc + LAT_B : -1});
        end
        @(posedge clk); #1;
        in_valid_b = 3'b000;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb0.size() == 0 && qb1.size() == 0) break;
        end
        if (k == 300) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b1;
        op_a = PE_OR;  in_data_a = '0; in_valid_a = '0; out_ready_a = 1'b1;
        op_b = PE_ADD; in_data_b = '0; in_valid_b = '0; out_ready_b = 2'b11;

        // Reset held for 3 cycles with every input valid
        @(posedge clk); #1;
        in_valid_a = 2'b11; in_data_a[0] = 16'hAAAA; in_data_a[1] = 16'h5555;
        in_valid_b = 3'b111; in_data_b[0] = 8'h12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready_a", {62'd0, in_ready_a}, 64'd0);
            chk("rst_out_valid_a", {63'd0, out_valid_a}, 64'd0);
            chk("rst_out_data_a", {48'd0, out_data_a}, 64'd0);
            chk("rst_fire_count_a", {32'd0, fire_count_a}, 64'd0);
            chk("rst_busy_a", {63'd0, busy_a}, 64'd0);
            chk("rst_in_ready_b", {61'd0, in_ready_b}, 64'd0);
            chk("rst_out_valid_b", {62'd0, out_valid_b}, 64'd0);
            chk("rst_busy_b", {63'd0, busy_b}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid_a = '0; in_valid_b = '0;

        // Single OR token, exact latency
        send_a(16'h00F0, 16'h0F00, PE_OR, 16'h0FF0, 1'b1);
        wait_drain();
        chk("or_fire_count", {32'd0, fire_count_a}, 64'd1);

        // Join: only one input valid must not fire
        in_data_a[0] = 16'h1234; in_data_a[1] = 16'h00FF; op_a = PE_AND;
        in_valid_a = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("join_partial_in_ready", {62'd0, in_ready_a}, 64'd0);
        end
        chk("join_partial_count", {32'd0, fire_count_a}, 64'd1);
        @(posedge clk); #1;
        in_valid_a = 2'b11;
        @(negedge clk);
        chk("join_full_in_ready", {62'd0, in_ready_a}, 64'd3);
        qa.push_back('{16'h0034, cyc + LAT_A});
        @(posedge clk); #1;
        in_valid_a = 2'b00;
        @(negedge clk);
        chk("join_after_in_ready", {62'd0, in_ready_a}, 64'd0);
        @(posedge clk); #1;
        wait_drain();
        chk("join_fire_count", {32'd0, fire_count_a}, 64'd2);

        // ADD stream: 0x80+0x90+0x05 wraps to 0x15
        for (int i = 0; i < 20; i++) send_b(8'h80, 8'h90, 8'h05, PE_ADD, 8'h15, 1'b1);
        wait_drain();
        chk("add_fire_count", {32'd0, fire_count_b}, 64'd20);

        // Fork backpressure: consumer 1 not ready
        out_ready_b = 2'b01;
        send_b(8'h11, 8'h22, 8'h44, PE_XOR, 8'h77, 1'b0);
        send_b(8'hA5, 8'h0F, 8'hF0, PE_XOR, 8'h5A, 1'b0);
        send_b(8'hFF, 8'h01, 8'h10, PE_XOR, 8'hEE, 1'b0);
        send_b(8'hF0, 8'h3C, 8'hFF, PE_AND, 8'h30, 1'b0);
        in_data_b[0] = 8'h01; in_data_b[1] = 8'h02; in_data_b[2] = 8'h03; op_b = PE_ADD;
        in_valid_b = 3'b111;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_b === 2'b11) break;
        end
        if (k == 20) chk("fork_head_timeout", 64'd1, 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("fork_out_valid", {62'd0, out_valid_b}, (i == 0) ? 64'd3 : 64'd2);
            chk("fork_out_data", {56'd0, out_data_b}, 64'h77);
            chk("fork_in_ready", {61'd0, in_ready_b}, 64'd0);
            chk("fork_busy", {63'd0, busy_b}, 64'd1);
        end
        @(posedge clk); #1;
        out_ready_b = 2'b11;
        send_b(8'h01, 8'h02, 8'h03, PE_ADD, 8'h06, 1'b0);
        wait_drain();
        chk("fork_fire_count", {32'd0, fire_count_b}, 64'd25);

        // Reset mid-flight with 5 tokens in DUT A
        for (int i = 0; i < 5; i++) send_a(16'(i), 16'h0100, PE_XOR, 16'h0000, 1'b0);
        qa.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_data_a[0] = 16'h7FFF; in_data_a[1] = 16'h0001; op_a = PE_ADD; in_valid_a = 2'b11;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy_a}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("midrst_fire_count", {32'd0, fire_count_a}, 64'd0);
        chk("midrst_in_ready", {62'd0, in_ready_a}, 64'd3);
        qa.push_back('{16'h8000, cyc + LAT_A});
        @(posedge clk); #1;
        in_valid_a = 2'b00;
        wait_drain();
        chk("midrst_fire_count_after", {32'd0, fire_count_a}, 64'd1);
        chk("queues_empty", 64'(qa.size() + qb0.size() + qb1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
